load_mem: RTL and testbench

LOAD_MEM -- requirements
Module: load_mem

---
 rtl/load_mem.sv | 128 ++++++++++++
 tb/tb_load_mem.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/load_mem.sv
// rtl/load_mem.sv - serial record loader: parses 01/COUNT/ADDR/DATA/CHECKSUM records into a 256x8 memory
// Reports each completed record with a one-cycle done pulse and a selectable error flag.

module load_mem_ram (
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata
);

   logic [7:0] M [0:255];

   // No reset: stored contents must survive a record abort or a reset.
   always_ff @(posedge clk) begin
      if (we) begin
         M[addr] <= wdata;
      end
   end

   assign rdata = M[addr];

endmodule

module load_mem (
   input  logic       clk,
   input  logic       resetN,
   input  logic [7:0] in,
   input  logic [1:0] TBerrorSelect,
   output logic       done,
   output logic       error
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_COUNT = 3'd1;
   localparam logic [2:0] S_ADDR  = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_CHECK = 3'd4;

   logic [2:0] state;
   logic [7:0] cnt;
   logic [7:0] base;
   logic [7:0] idx;
   logic [7:0] sum;

   logic [7:0] final_sum;
   logic       csum_err;
   logic       ovf_err;
   logic       sel_err;
   logic       last_data;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] unused_rdata;

   always_comb begin
      final_sum = sum + in;
      csum_err  = (final_sum != 8'd0);
      // 9-bit compare so base+cnt exactly reaching 256 is not flagged
      ovf_err   = (({1'b0, base} + {1'b0, cnt}) > 9'd256);
      last_data = (({1'b0, idx} + 9'd1) == {1'b0, cnt});
      case (TBerrorSelect)
         2'b00:   sel_err = csum_err;
         2'b01:   sel_err = ovf_err;
         2'b10:   sel_err = 1'b1;
         default: sel_err = csum_err | ovf_err;
      endcase
   end

   assign mem_we   = (state == S_DATA);
   assign mem_addr = base + idx;

   load_mem_ram M (
      .clk   (clk),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (in),
      .rdata (unused_rdata)
   );

   always_ff @(posedge clk or posedge resetN) begin
      if (resetN) begin
         state <= S_IDLE;
         cnt   <= 8'd0;
         base  <= 8'd0;
         idx   <= 8'd0;
         sum   <= 8'd0;
         done  <= 1'b0;
         error <= 1'b0;
      end else begin
         done  <= 1'b0;
         error <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in == 8'h01) begin
                  state <= S_COUNT;
               end
            end
            S_COUNT: begin
               cnt   <= in;
               sum   <= in;
               state <= S_ADDR;
            end
            S_ADDR: begin
               base  <= in;
               sum   <= sum + in;
               idx   <= 8'd0;
               state <= (cnt != 8'd0) ? S_DATA : S_CHECK;
            end
            S_DATA: begin
               sum <= sum + in;
               idx <= idx + 8'd1;
               if (last_data) begin
                  state <= S_CHECK;
               end
            end
            S_CHECK: begin
               done  <= 1'b1;
               error <= sel_err;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_mem.sv
// tb/tb_load_mem.sv - directed and random record checks for load_mem

module tb_load_mem;

   logic       clk = 1'b0;
   logic       resetN;
   logic [7:0] in;
   logic [1:0] TBerrorSelect;
   logic       done;
   logic       error;

   int checks = 0;
   int errors = 0;

   load_mem dut (
      .clk           (clk),
      .resetN        (resetN),
      .in            (in),
      .TBerrorSelect (TBerrorSelect),
      .done          (done),
      .error         (error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]  sel;
      logic [63:0] stream;
      logic [3:0]  n;
      logic        err;
      logic [47:0] wr;
      logic [1:0]  nw;
   } vec_t;

   vec_t vecs [10];

   logic [7:0] mdl [256];
   bit         mv  [256];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic feed(input logic [7:0] b);
      @(negedge clk);
      chk("done_low_while_feeding", {31'd0, done}, 32'd0);
      in = b;
   endtask

   initial begin
      vecs[0] = '{2'b11, 64'h010310AABBCCBC00, 4'd7, 1'b0, 48'h10AA11BB12CC, 2'd3};
      vecs[1] = '{2'b11, 64'h0102201122000000, 4'd6, 1'b1, 48'h201121220000, 2'd2};
      vecs[2] = '{2'b01, 64'h0102201122000000, 4'd6, 1'b0, 48'h201121220000, 2'd2};
      vecs[3] = '{2'b11, 64'h010140338C000000, 4'd5, 1'b0, 48'h403300000000, 2'd1};
      vecs[4] = '{2'b11, 64'h010040C000000000, 4'd4, 1'b0, 48'h403300000000, 2'd1};
      vecs[5] = '{2'b01, 64'h0102FF5AA5000000, 4'd6, 1'b1, 48'hFF5A00A50000, 2'd2};
      vecs[6] = '{2'b00, 64'h0102FF5AA5000000, 4'd6, 1'b0, 48'hFF5A00A50000, 2'd2};
      vecs[7] = '{2'b10, 64'h0101507738000000, 4'd5, 1'b1, 48'h507700000000, 2'd1};
      vecs[8] = '{2'b11, 64'h01026001019C0000, 4'd6, 1'b0, 48'h600161010000, 2'd2};
      vecs[9] = '{2'b10, 64'h010040C000000000, 4'd4, 1'b1, 48'h000000000000, 2'd0};

      resetN = 1'b1;
      in = 8'h00;
      TBerrorSelect = 2'b11;
      #1;
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_error", {31'd0, error}, 32'd0);
      repeat (2) @(negedge clk);
      resetN = 1'b0;

      for (int v = 0; v < 10; v++) begin
         TBerrorSelect = vecs[v].sel;
         for (int i = 0; i < int'(vecs[v].n); i++) begin
            feed(vecs[v].stream[63-8*i -: 8]);
         end
         @(negedge clk);
         in = 8'h00;
         chk($sformatf("vec%0d_done", v), {31'd0, done}, 32'd1);
         chk($sformatf("vec%0d_error", v), {31'd0, error}, {31'd0, vecs[v].err});
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse", v), {31'd0, done}, 32'd0);
         chk($sformatf("vec%0d_error_idle", v), {31'd0, error}, 32'd0);
         for (int w = 0; w < int'(vecs[v].nw); w++) begin
            logic [15:0] pr;
            pr = vecs[v].wr[47-16*w -: 16];
            chk($sformatf("vec%0d_mem%02h", v, pr[15:8]), {24'd0, dut.M.M[pr[15:8]]}, {24'd0, pr[7:0]});
         end
      end

      // Idle bytes other than 0x01 must be ignored even with forced error.
      TBerrorSelect = 2'b10;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in = (i % 2 == 0) ? 8'h00 : 8'h7F;
         chk("idle_no_done", {31'd0, done}, 32'd0);
         chk("idle_no_error", {31'd0, error}, 32'd0);
      end

      // Reset mid-record: abort without done, earlier write persists.
      TBerrorSelect = 2'b11;
      feed(8'h01);
      feed(8'h02);
      feed(8'h70);
      feed(8'h44);
      @(negedge clk);
      resetN = 1'b1;
      in = 8'h55;
      #1;
      chk("midreset_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      resetN = 1'b0;
      chk("midreset_mem70", {24'd0, dut.M.M[8'h70]}, 32'h44);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_reset_no_done", {31'd0, done}, 32'd0);
      end
      feed(8'h01);
      feed(8'h00);
      feed(8'h80);
      feed(8'h80);
      @(negedge clk);
      in = 8'h00;
      chk("post_reset_rec_done", {31'd0, done}, 32'd1);
      chk("post_reset_rec_error", {31'd0, error}, 32'd0);

      // Back-to-back random records against a byte-level memory model.
      for (int k = 0; k < 256; k++) mv[k] = 1'b0;
      for (int r = 0; r < 100; r++) begin
         int         c;
         int         a;
         logic [7:0] s;
         logic [7:0] d;
         logic [7:0] q [$];
         c = int'($urandom_range(0, 19));
         a = int'($urandom_range(0, (c == 0) ? 255 : 256 - c));
         q = {};
         q.push_back(8'h01);
         q.push_back(c[7:0]);
         q.push_back(a[7:0]);
         s = c[7:0] + a[7:0];
         for (int k = 0; k < c; k++) begin
            d = 8'($urandom);
            q.push_back(d);
            s = s + d;
            mdl[(a + k) % 256] = d;
            mv[(a + k) % 256]  = 1'b1;
         end
         q.push_back(8'h00 - s);
         for (int j = 0; j < q.size(); j++) begin
            @(negedge clk);
            if (j == 0 && r > 0) begin
               chk($sformatf("rand%0d_done", r - 1), {31'd0, done}, 32'd1);
               chk($sformatf("rand%0d_error", r - 1), {31'd0, error}, 32'd0);
            end else begin
               chk("rand_done_low", {31'd0, done}, 32'd0);
            end
            in = q[j];
         end
      end
      @(negedge clk);
      in = 8'h00;
      chk("rand99_done", {31'd0, done}, 32'd1);
      chk("rand99_error", {31'd0, error}, 32'd0);
      for (int k = 0; k < 256; k++) begin
         if (mv[k]) begin
            chk($sformatf("rand_mem%02h", k), {24'd0, dut.M.M[k]}, {24'd0, mdl[k]});
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
